// File: rtl/kc_pkg.sv
// Shared constants and helpers for the key/switch conditioner.
package kc_pkg;

  // 10 ms of settling at a 100 MHz system clock.
  localparam int KC_DB_CYCLES_DEF = 1000000;

  // Short settling time for simulation.
  localparam int KC_DB_CYCLES_SIM = 16;

  // Debounce counter width: the counter only has to reach db_cycles-1.
  function automatic int kc_cnt_w(input int db_cycles);
    return (db_cycles > 2) ? $clog2(db_cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer, optional inversion, counter-based
// debounce filter and registered single-cycle press/release pulses.
module debounce_bit
  import kc_pkg::*;
#(
  parameter int DB_CYCLES = KC_DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic invert,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = kc_cnt_w(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             lvl_in;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronizer; resets to the idle pin level so the logical level starts at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= invert;
      s2_q <= invert;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  assign lvl_in = s2_q ^ invert;

  // Accept a new level only after it has persisted for DB_CYCLES edges; any glitch restarts the count.
  always_comb begin
    lvl_d  = lvl_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (lvl_in == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d  = lvl_in;
      cnt_d  = '0;
      rise_d = lvl_in;
      fall_d = ~lvl_in;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state and pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/key_switch_conditioner.sv
// Conditions raw pushbutton/switch pins into debounced levels, edge pulses
// and sticky per-bit press capture flags with write-1-to-clear.
module key_switch_conditioner
  import kc_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               DB_CYCLES   = KC_DB_CYCLES_DEF,
  parameter logic [WIDTH-1:0] INVERT_MASK = 4'hF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_i,
  input  logic [WIDTH-1:0] clear_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] capture_o
);

  logic [WIDTH-1:0] cap_q, cap_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw_i[i]),
      .invert (INVERT_MASK[i]),
      .level  (level_o[i]),
      .rise   (rise_o[i]),
      .fall   (fall_o[i])
    );
  end

  // cap_q holds the capture state with clears applied; the rise pulse that
  // registers at the same edge is OR'd in on the output. Because rise_o is
  // itself a register updated with the same edge, this is equivalent to
  // capturing (capture & ~clear) | rise_next, so a set always beats a clear.
  always_comb begin
    cap_d = capture_o & ~clear_i;
  end

  // Capture register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign capture_o = cap_q | rise_o;

endmodule

// File: tb/tb_key_switch_conditioner.sv
module tb_key_switch_conditioner;
  import kc_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] raw_i;
  logic [W-1:0] clear_i;
  logic [W-1:0] level_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic [W-1:0] capture_o;

  int n_cmp;
  int n_err;
  logic [W-1:0] seen_pulse;
  logic [W-1:0] seen_level;

  key_switch_conditioner #(
    .WIDTH      (W),
    .DB_CYCLES  (KC_DB_CYCLES_SIM),
    .INVERT_MASK(4'hF)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_i    (raw_i),
    .clear_i  (clear_i),
    .level_o  (level_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .capture_o(capture_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles; each call ends just after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance n cycles, collecting any pulse and any level_o bit seen high on mask m.
  task automatic step_watch(input int n, input logic [W-1:0] m);
    repeat (n) begin
      @(negedge clk);
      seen_pulse = seen_pulse | ((rise_o | fall_o) & m);
      seen_level = seen_level | (level_o & m);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    seen_pulse = '0;
    seen_level = '0;
    reset_n    = 1'b0;
    raw_i      = 4'hF;
    clear_i    = 4'h0;

    // 1. reset with all pins idle (high)
    step(3);
    chk("rst_level", level_o, 4'h0);
    chk("rst_capture", capture_o, 4'h0);
    chk("rst_pulses", rise_o | fall_o, 4'h0);
    reset_n = 1'b1;
    step_watch(200, 4'hF);
    chk("idle_pulses", seen_pulse, 4'h0);
    chk("idle_level", seen_level, 4'h0);
    chk("idle_capture", capture_o, 4'h0);

    // 2. press bit 0: level at edge k+17
    raw_i = 4'hE;
    step(17);
    chk("p0_before_level", level_o, 4'h0);
    chk("p0_before_rise", rise_o, 4'h0);
    step(1);
    chk("p0_level", level_o, 4'h1);
    chk("p0_rise", rise_o, 4'h1);
    chk("p0_capture", capture_o, 4'h1);
    step(1);
    chk("p0_rise_once", rise_o, 4'h0);
    chk("p0_capture_hold", capture_o, 4'h1);

    // 3. bounce on bit 1 must not be accepted
    seen_pulse = '0;
    seen_level = '0;
    raw_i = 4'hC;
    step_watch(10, 4'h2);
    raw_i = 4'hE;
    step_watch(2, 4'h2);
    raw_i = 4'hC;
    step_watch(10, 4'h2);
    chk("b1_bounce_pulses", seen_pulse, 4'h0);
    chk("b1_bounce_level", seen_level, 4'h0);
    step(7);
    chk("b1_before_rise", rise_o, 4'h0);
    step(1);
    chk("b1_rise", rise_o, 4'h2);
    chk("b1_level", level_o, 4'h3);
    step(1);
    chk("b1_rise_once", rise_o, 4'h0);
    chk("b1_capture", capture_o, 4'h3);

    // 4a. clear bit 0 capture
    clear_i = 4'h1;
    step(1);
    clear_i = 4'h0;
    chk("clr0_capture", capture_o, 4'h2);
    step(1);
    chk("clr0_stays", capture_o, 4'h2);

    // 5. release bit 0
    raw_i = 4'hD;
    step(17);
    chk("r0_before_fall", fall_o, 4'h0);
    chk("r0_before_level", level_o, 4'h3);
    step(1);
    chk("r0_fall", fall_o, 4'h1);
    chk("r0_no_rise", rise_o, 4'h0);
    chk("r0_level", level_o, 4'h2);
    chk("r0_capture", capture_o, 4'h2);
    step(1);
    chk("r0_fall_once", fall_o, 4'h0);

    // 4b. clear coincident with a new rise on bit 0: set wins
    raw_i = 4'hC;
    step(17);
    clear_i = 4'h1;
    step(1);
    chk("setclr_rise", rise_o, 4'h1);
    chk("setclr_capture", capture_o, 4'h3);
    step(1);
    chk("clrheld_capture", capture_o, 4'h2);
    clear_i = 4'h0;
    step(1);
    chk("clrrel_capture", capture_o, 4'h2);

    // 6. reset mid-count on bit 2, pin still low afterwards
    raw_i = 4'h8;
    step(12);
    reset_n = 1'b0;
    step(2);
    chk("mid_rst_level", level_o, 4'h0);
    chk("mid_rst_capture", capture_o, 4'h0);
    reset_n = 1'b1;
    seen_pulse = '0;
    seen_level = '0;
    step_watch(17, 4'hF);
    chk("post_rst_pulses", seen_pulse, 4'h0);
    chk("post_rst_level", seen_level, 4'h0);
    step(1);
    chk("post_rst_rise", rise_o, 4'h7);
    chk("post_rst_level_up", level_o, 4'h7);
    chk("post_rst_capture", capture_o, 4'h7);
    step(1);
    chk("post_rst_rise_once", rise_o, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
